// File: rtl/sm4_rk_sched_if.sv
// Key-load and round-key streaming bundle between the SM4 key-schedule engine and its users.
interface sm4_rk_sched_if;
    logic [0:127] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         start;
    logic         dec_mode;
    logic [0:31]  rk_out;
    logic [4:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         keys_ok;

    modport master (output key_in, key_valid, start, dec_mode, rk_ready,
                    input  key_ready, rk_out, rk_idx, rk_valid, busy, keys_ok);
    modport slave  (input  key_in, key_valid, start, dec_mode, rk_ready,
                    output key_ready, rk_out, rk_idx, rk_valid, busy, keys_ok);
endinterface

// File: rtl/sm4_rk_sched.sv
// SM4 key schedule: expands a master key into rk0..rk31 at one round per clock, stores
// them, then streams them forward or reverse over a valid/ready handshake.
module sm4_rk_sched #(
    parameter int NRND = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    sm4_rk_sched_if.slave sif
);
    typedef enum logic [1:0] {IDLE, EXPAND, HOLD, SERVE} state_t;

    localparam logic [4:0]   LAST = 5'(NRND - 1);
    localparam logic [127:0] FK   = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
    localparam logic [2047:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    // Entry 0 sits in the top byte, so the bit offset of entry x is (255-x)*8 = {~x, 000}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] off;
        off = {~x, 3'b000};
        return SBOX[off +: 8];
    endfunction

    function automatic logic [31:0] t_prime(input logic [31:0] a);
        logic [31:0] b;
        for (int j = 0; j < 4; j++) b[8*j +: 8] = sbox(a[8*j +: 8]);
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

    function automatic logic [31:0] ck_gen(input logic [4:0] i);
        logic [31:0] ck;
        logic [7:0]  n;
        for (int j = 0; j < 4; j++) begin
            n = {1'b0, i, 2'b00} + 8'(j);
            ck[8*(3-j) +: 8] = 8'(n * 8'd7);
        end
        return ck;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] k_q [4];
    logic [31:0] k_d [4];
    logic [31:0] store_q [NRND];
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  ptr_q, ptr_d, ptr_nx, ptr_first, ptr_end;
    logic        keys_ok_q, keys_ok_d;
    logic        dir_q, dir_d;
    logic        rk_valid_q, rk_valid_d;
    logic [31:0] rk_out_q, rk_out_d;
    logic [31:0] rk_new;
    logic [127:0] mk;
    logic        st_we;

    assign mk = sif.key_in;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        keys_ok_d  = keys_ok_q;
        dir_d      = dir_q;
        ptr_d      = ptr_q;
        rk_valid_d = rk_valid_q;
        rk_out_d   = rk_out_q;
        st_we      = 1'b0;
        rk_new     = k_q[0] ^ t_prime(k_q[1] ^ k_q[2] ^ k_q[3] ^ ck_gen(cnt_q));
        ptr_nx     = dir_q ? ptr_q - 5'd1 : ptr_q + 5'd1;
        ptr_first  = sif.dec_mode ? LAST : 5'd0;
        ptr_end    = dir_q ? 5'd0 : LAST;
        unique case (state_q)
            IDLE, HOLD: begin
                if (sif.key_valid) begin
                    for (int i = 0; i < 4; i++) k_d[i] = mk[127-32*i -: 32] ^ FK[127-32*i -: 32];
                    cnt_d     = 5'd0;
                    keys_ok_d = 1'b0;
                    state_d   = EXPAND;
                end else if (state_q == HOLD && sif.start) begin
                    dir_d      = sif.dec_mode;
                    ptr_d      = ptr_first;
                    rk_out_d   = store_q[ptr_first];
                    rk_valid_d = 1'b1;
                    state_d    = SERVE;
                end
            end
            EXPAND: begin
                st_we = 1'b1;
                k_d   = '{k_q[1], k_q[2], k_q[3], rk_new};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST) begin
                    keys_ok_d = 1'b1;
                    state_d   = HOLD;
                end
            end
            SERVE: begin
                // Prefetch the next key on each handshake so the stream has no bubbles.
                if (sif.rk_ready) begin
                    if (ptr_q == ptr_end) begin
                        rk_valid_d = 1'b0;
                        state_d    = HOLD;
                    end else begin
                        ptr_d    = ptr_nx;
                        rk_out_d = store_q[ptr_nx];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            keys_ok_q  <= 1'b0;
            dir_q      <= 1'b0;
            ptr_q      <= 5'd0;
            rk_valid_q <= 1'b0;
            rk_out_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            keys_ok_q  <= keys_ok_d;
            dir_q      <= dir_d;
            ptr_q      <= ptr_d;
            rk_valid_q <= rk_valid_d;
            rk_out_q   <= rk_out_d;
        end
    end

    always_ff @(posedge clk) begin
        k_q <= k_d;
        if (st_we) store_q[cnt_q] <= rk_new;
    end

    assign sif.key_ready = (state_q == IDLE) || (state_q == HOLD);
    assign sif.busy      = (state_q == EXPAND) || (state_q == SERVE);
    assign sif.keys_ok   = keys_ok_q;
    assign sif.rk_valid  = rk_valid_q;
    assign sif.rk_out    = rk_out_q;
    assign sif.rk_idx    = ptr_q;
endmodule
